// File: rtl/mux_n_skid.sv
// mux_n_skid: N-way channel select feeding a two-entry skid buffer.
// The selected channel is registered into a main/skid register pair, so both
// in_ready and out_valid come from flops and out_ready has no combinational
// path back to in_ready. Out-of-range selects emit DEFAULT_VALUE and set a
// sticky error flag.
module mux_n_skid #(
  parameter int                DATA_W        = 16,
  parameter int                N_INPUTS      = 3,
  parameter int                SEL_W         = 2,
  parameter logic [DATA_W-1:0] DEFAULT_VALUE = {DATA_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         err_clr,
  input  logic [N_INPUTS*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]             in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sel_err,
  output logic [1:0]                   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // One extra bit so that N_INPUTS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] N_LIMIT = (SEL_W+1)'(N_INPUTS);

  // Loop-based mux: every select value resolves to a defined channel or the
  // default, so no X and no latch for out-of-range selects.
  function automatic logic [DATA_W-1:0] select_channel(
    input logic [N_INPUTS*DATA_W-1:0] data,
    input logic [SEL_W-1:0]           sel
  );
    logic [DATA_W-1:0] pick;
    pick = DEFAULT_VALUE;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        pick = data[k*DATA_W +: DATA_W];
      end
    end
    return pick;
  endfunction

  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel);
    return ({1'b0, sel} >= N_LIMIT);
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   skid_r;
  logic [DATA_W-1:0]   main_nxt_s;
  logic [DATA_W-1:0]   skid_nxt_s;
  logic                out_valid_r;
  logic                in_ready_r;
  logic [1:0]          occupancy_r;
  logic                sel_err_r;
  logic                sel_err_nxt_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic                sel_oor_s;
  logic [DATA_W-1:0]   sel_data_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;
  assign sel_oor_s  = sel_out_of_range(in_sel);
  assign sel_data_s = select_channel(in_data, in_sel);

  // Next-state and storage steering for the main/skid register pair.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = sel_data_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s && !out_xfer_s) begin
          state_nxt_s = TWO;
          skid_nxt_s  = sel_data_s;
        end else if (in_xfer_s && out_xfer_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = sel_data_s;
        end else if (out_xfer_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        if (out_xfer_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = skid_r;
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
    // Flush drops everything, including an entry offered in this cycle.
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Sticky select error: a new error wins over a simultaneous clear.
  always_comb begin
    sel_err_nxt_s = sel_err_r;
    if (in_xfer_s && sel_oor_s) begin
      sel_err_nxt_s = 1'b1;
    end else if (err_clr) begin
      sel_err_nxt_s = 1'b0;
    end else begin
      sel_err_nxt_s = sel_err_r;
    end
  end

  // State, storage and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= DEFAULT_VALUE;
      skid_r      <= DEFAULT_VALUE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
      sel_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
      in_ready_r  <= (state_nxt_s != TWO);
      occupancy_r <= state_nxt_s;
      sel_err_r   <= sel_err_nxt_s;
    end
  end

  assign out_data  = main_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign occupancy = occupancy_r;
  assign sel_err   = sel_err_r;

endmodule
